// File: rtl/led_strip_tx.sv
// Streams NUM_LEDS pixel words from a Wishbone-readable LED buffer onto a
// single-wire WS2812-style strip, with a one-word prefetch buffer for gap-free bits.
module led_strip_tx #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_LEDS   = 8,
    parameter int unsigned T0H        = 20,
    parameter int unsigned T1H        = 40,
    parameter int unsigned TBIT       = 63,
    parameter int unsigned TRESET     = 2500
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] wbm_address,
    output logic [DATA_WIDTH-1:0] wbm_writedata,
    input  logic [DATA_WIDTH-1:0] wbm_readdata,
    output logic                  wbm_strobe,
    output logic                  wbm_cycle,
    output logic                  wbm_write,
    input  logic                  wbm_ack,
    input  logic                  led_tx,
    input  logic [DATA_WIDTH-1:0] led_tx_buf_id,
    output logic                  led_tx_done,
    output logic                  led_data
);

    localparam int unsigned BYTES_PER_WORD = DATA_WIDTH / 8;
    localparam int unsigned BUF_BYTES      = NUM_LEDS * BYTES_PER_WORD;
    localparam int unsigned PROD_W         = ADDR_WIDTH + DATA_WIDTH;
    localparam int unsigned PIX_W          = 24;
    localparam int unsigned CNT_W          = $clog2(NUM_LEDS + 1);
    localparam int unsigned TMR_MAX        = (TBIT > TRESET) ? TBIT : TRESET;
    localparam int unsigned TMR_W          = $clog2(TMR_MAX + 1);

    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(NUM_LEDS);
    localparam logic [TMR_W-1:0] TBIT_END   = TMR_W'(TBIT - 1);
    localparam logic [TMR_W-1:0] TRESET_END = TMR_W'(TRESET - 1);
    localparam logic [TMR_W-1:0] T0H_C      = TMR_W'(T0H);
    localparam logic [TMR_W-1:0] T1H_C      = TMR_W'(T1H);
    localparam logic [4:0]       MSB_IDX    = 5'(PIX_W - 1);

    localparam logic [1:0] F_IDLE = 2'd0;
    localparam logic [1:0] F_READ = 2'd1;
    localparam logic [1:0] F_WAIT = 2'd2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_BIT   = 3'd2;
    localparam logic [2:0] S_LATCH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [1:0]            f_state, f_next;
    logic [2:0]            s_state, s_next;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CNT_W-1:0]      fetch_idx;
    logic [CNT_W-1:0]      word_cnt;
    logic [PIX_W-1:0]      pbuf;
    logic                  pbuf_valid;
    logic [PIX_W-1:0]      shreg;
    logic [4:0]            bit_idx;
    logic [TMR_W-1:0]      tmr;

    logic start_c, ack_c, bit_end_c, word_end_c, last_word_c, load_c, level_c;
    logic unused_readdata;

    // Buffers are laid out back to back, one NUM_LEDS-word block per id.
    function automatic logic [ADDR_WIDTH-1:0] addr_for_buf_id(input logic [DATA_WIDTH-1:0] id);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(id) * PROD_W'(BUF_BYTES);
        return prod[ADDR_WIDTH-1:0];
    endfunction

    assign unused_readdata = ^wbm_readdata[DATA_WIDTH-1:PIX_W];

    assign start_c     = (s_state == S_IDLE) && led_tx;
    assign ack_c       = (f_state == F_READ) && wbm_ack;
    assign bit_end_c   = (s_state == S_BIT) && (tmr == TBIT_END);
    assign word_end_c  = bit_end_c && (bit_idx == 5'd0);
    assign last_word_c = (word_cnt == LAST_CNT);
    assign load_c      = pbuf_valid &&
                         ((s_state == S_LOAD) || (word_end_c && !last_word_c));
    assign level_c     = (s_state == S_BIT) && (tmr < (shreg[bit_idx] ? T1H_C : T0H_C));

    assign wbm_cycle     = (f_state == F_READ);
    assign wbm_strobe    = (f_state == F_READ);
    assign wbm_address   = (f_state == F_READ) ? addr_q : '0;
    assign wbm_write     = 1'b0;
    assign wbm_writedata = '0;

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_state <= F_IDLE;
            s_state <= S_IDLE;
        end else begin
            f_state <= f_next;
            s_state <= s_next;
        end
    end

    // Fetch next state: one outstanding read, only into an empty prefetch buffer
    always_comb begin
        f_next = f_state;
        case (f_state)
            F_IDLE: if (start_c) f_next = F_READ;
            F_READ: if (wbm_ack) f_next = F_WAIT;
            F_WAIT: if (!pbuf_valid) f_next = (fetch_idx == LAST_CNT) ? F_IDLE : F_READ;
            default: f_next = F_IDLE;
        endcase
    end

    // Serializer next state
    always_comb begin
        s_next = s_state;
        case (s_state)
            S_IDLE:  if (led_tx) s_next = S_LOAD;
            S_LOAD:  if (pbuf_valid) s_next = S_BIT;
            S_BIT: begin
                if (word_end_c) begin
                    if (last_word_c)      s_next = S_LATCH;
                    else if (!pbuf_valid) s_next = S_LOAD;
                end
            end
            S_LATCH: if (tmr == TRESET_END) s_next = S_DONE;
            S_DONE:  s_next = S_IDLE;
            default: s_next = S_IDLE;
        endcase
    end

    // Datapath, counters and registered strip outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q      <= '0;
            fetch_idx   <= '0;
            word_cnt    <= '0;
            pbuf        <= '0;
            pbuf_valid  <= 1'b0;
            shreg       <= '0;
            bit_idx     <= '0;
            tmr         <= '0;
            led_data    <= 1'b0;
            led_tx_done <= 1'b0;
        end else begin
            if (start_c) begin
                addr_q    <= addr_for_buf_id(led_tx_buf_id);
                fetch_idx <= '0;
                word_cnt  <= '0;
            end
            if (ack_c) begin
                pbuf      <= wbm_readdata[PIX_W-1:0];
                addr_q    <= addr_q + ADDR_WIDTH'(BYTES_PER_WORD);
                fetch_idx <= fetch_idx + CNT_W'(1);
            end

            if (load_c)     pbuf_valid <= 1'b0;
            else if (ack_c) pbuf_valid <= 1'b1;

            if (load_c) begin
                shreg    <= pbuf;
                bit_idx  <= MSB_IDX;
                tmr      <= '0;
                word_cnt <= word_cnt + CNT_W'(1);
            end else if (bit_end_c) begin
                tmr <= '0;
                if (bit_idx != 5'd0) bit_idx <= bit_idx - 5'd1;
            end else if (s_state == S_LATCH) begin
                tmr <= (tmr == TRESET_END) ? '0 : tmr + TMR_W'(1);
            end else if (s_state == S_BIT) begin
                tmr <= tmr + TMR_W'(1);
            end

            led_data    <= level_c;
            led_tx_done <= (s_next == S_DONE);
        end
    end

endmodule

// File: tb/tb_led_strip_tx.sv
// Randomized bench for led_strip_tx: Wishbone memory model plus a waveform monitor
// that decodes strip pulses and compares them with bits expected from the buffer words.
module tb_led_strip_tx;

    localparam int unsigned N      = 2;
    localparam int unsigned T0H    = 20;
    localparam int unsigned T1H    = 40;
    localparam int unsigned TBIT   = 63;
    localparam int unsigned TRESET = 2500;
    localparam int          BUDGET = 24 * N * TBIT + TRESET + 200;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wbm_address, wbm_writedata, wbm_readdata;
    logic        wbm_strobe, wbm_cycle, wbm_write, wbm_ack;
    logic        led_tx;
    logic [31:0] led_tx_buf_id;
    logic        led_tx_done, led_data;

    led_strip_tx #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_LEDS(N),
        .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET)
    ) dut (
        .clk(clk), .reset(reset),
        .wbm_address(wbm_address), .wbm_writedata(wbm_writedata),
        .wbm_readdata(wbm_readdata), .wbm_strobe(wbm_strobe),
        .wbm_cycle(wbm_cycle), .wbm_write(wbm_write), .wbm_ack(wbm_ack),
        .led_tx(led_tx), .led_tx_buf_id(led_tx_buf_id),
        .led_tx_done(led_tx_done), .led_data(led_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strip/bus monitor, sampled mid-cycle
    int   rise_q[$];
    int   len_q[$];
    int   done_q[$];
    int   rise_start = 0;
    int   wr_seen    = 0;
    logic prev_data  = 1'b0;
    always @(negedge clk) begin
        if (led_data && !prev_data) begin
            rise_start = cyc;
            rise_q.push_back(cyc);
        end
        if (!led_data && prev_data) len_q.push_back(cyc - rise_start);
        if (led_tx_done) done_q.push_back(cyc);
        if (wbm_write !== 1'b0 || wbm_writedata !== 32'h0) wr_seen++;
        prev_data = led_data;
    end

    // Wishbone slave: ack after a per-read delay (cycles after strobe first seen)
    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_addr[$];
    int          ack_delay[$];
    initial begin : slave
        int          d;
        logic [31:0] a;
        wbm_ack      = 1'b0;
        wbm_readdata = 32'h0;
        forever begin
            @(negedge clk);
            if (wbm_strobe && wbm_cycle) begin
                a = wbm_address;
                d = (rd_addr.size() < ack_delay.size()) ? ack_delay[rd_addr.size()] : 1;
                rd_addr.push_back(a);
                repeat (d) @(negedge clk);
                wbm_ack      = 1'b1;
                wbm_readdata = mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
                @(negedge clk);
                wbm_ack      = 1'b0;
                wbm_readdata = 32'h0;
            end
        end
    end

    function automatic logic [31:0] model_addr(input logic [31:0] id, input int i);
        longint unsigned b;
        b = {32'h0, id};
        b = b * N * 4 + 64'(4 * i);
        return b[31:0];
    endfunction

    task automatic load_words(input logic [31:0] id, input logic [31:0] w0, input logic [31:0] w1);
        mem[model_addr(id, 0)] = w0;
        mem[model_addr(id, 1)] = w1;
    endtask

    task automatic start_xfer(input logic [31:0] id, output int k0);
        @(negedge clk);
        rise_q.delete(); len_q.delete(); done_q.delete(); rd_addr.delete();
        led_tx_buf_id = id;
        led_tx        = 1'b1;
        k0            = cyc;
    endtask

    // Requester holds led_tx through the done cycle and drops it one edge later
    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (led_tx_done) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        led_tx = 1'b0;
    endtask

    // Counts pulse-width and bit-period deviations from the expected bit stream
    task automatic wave_errors(input logic [31:0] w0, input logic [31:0] w1, input int gap_at,
                               output int n_len, output int n_per);
        int          exp_len[$];
        logic [31:0] ws [2];
        ws[0] = w0;
        ws[1] = w1;
        n_len = 0;
        n_per = 0;
        for (int w = 0; w < 2; w++)
            for (int b = 23; b >= 0; b--) exp_len.push_back(ws[w][b] ? int'(T1H) : int'(T0H));
        if (len_q.size() != exp_len.size()) n_len = 1000 + len_q.size();
        else for (int i = 0; i < exp_len.size(); i++) if (len_q[i] != exp_len[i]) n_len++;
        for (int i = 0; i + 1 < rise_q.size(); i++)
            if (i != gap_at && rise_q[i+1] - rise_q[i] != int'(TBIT)) n_per++;
    endtask

    task automatic test_reset;
        reset = 1'b1; led_tx = 1'b0; led_tx_buf_id = 32'h0;
        repeat (3) @(posedge clk); #1;
        total++; if (led_data !== 1'b0) begin bad++; $display("FAIL reset_led_data got=%b want=0", led_data); end
        total++; if (led_tx_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", led_tx_done); end
        total++; if ({wbm_cycle, wbm_strobe, wbm_write} !== 3'b000) begin bad++;
            $display("FAIL reset_wb_ctl got=%b want=000", {wbm_cycle, wbm_strobe, wbm_write}); end
        total++; if (wbm_address !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", wbm_address); end
        @(negedge clk); reset = 1'b0;
    endtask

    // Full transfer with ack delays, checked against the model
    task automatic run_checked(input string name, input logic [31:0] id, input logic [31:0] w0,
                               input logic [31:0] w1, input int d1);
        int k0, n_len, n_per, gap;
        bit ok;
        ack_delay.delete(); ack_delay.push_back(1); ack_delay.push_back(d1);
        load_words(id, w0, w1);
        start_xfer(id, k0);
        wait_done(BUDGET + d1, ok);
        repeat (10) @(posedge clk); #1;
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL %s_timeout got=no_done want=done", name); end
        total++; if (rise_q.size() == 0 || rise_q[0] != k0 + 5) begin bad++;
            $display("FAIL %s_latency got=%0d want=%0d", name, rise_q.size() ? rise_q[0] - k0 : -1, 5); end
        gap = (d1 > int'(24 * TBIT)) ? 23 : -1;
        wave_errors(w0, w1, gap, n_len, n_per);
        total++; if (n_len !== 0) begin bad++; $display("FAIL %s_pulses got=%0d_errs want=0", name, n_len); end
        total++; if (n_per !== 0) begin bad++; $display("FAIL %s_period got=%0d_errs want=0", name, n_per); end
        if (gap >= 0) begin
            total++; if (rise_q.size() < 25 || rise_q[24] != rise_q[0] + d1 + 3) begin bad++;
                $display("FAIL %s_underrun got=%0d want=%0d", name,
                         rise_q.size() >= 25 ? rise_q[24] - rise_q[0] : -1, d1 + 3); end
        end
        total++; if (done_q.size() != 1 || rise_q.size() == 0 ||
                     done_q[0] != rise_q[rise_q.size()-1] + int'(TBIT) - 1 + int'(TRESET)) begin bad++;
            $display("FAIL %s_done got=%0d_pulses want=1_at_latch_end", name, done_q.size()); end
        total++; if (rd_addr.size() != N || rd_addr[0] !== model_addr(id, 0) || rd_addr[1] !== model_addr(id, 1)) begin
            bad++; $display("FAIL %s_reads got=%0d_reads want=%0d_at_%h", name, rd_addr.size(), N, model_addr(id, 0)); end
        total++; if (wbm_cycle !== 1'b0) begin bad++; $display("FAIL %s_idle_cycle got=%b want=0", name, wbm_cycle); end
    endtask

    task automatic test_basic;
        run_checked("basic", $urandom(), 32'h00FF00AA, 32'h00000001, 1);
    endtask

    task automatic test_upper_byte;
        run_checked("upper", $urandom(), 32'hAB000000, {8'($urandom()), 24'h0}, 1);
    endtask

    task automatic test_addressing;
        run_checked("addr", 32'd3, $urandom(), $urandom(), 1);
        total++; if (wr_seen !== 0) begin bad++; $display("FAIL addr_write got=%0d want=0", wr_seen); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 2; i++)
            run_checked("rand", $urandom(), $urandom(), $urandom(), $urandom_range(1, 30));
    endtask

    task automatic test_underrun;
        run_checked("underrun", $urandom(), $urandom(), $urandom(), 2000);
    endtask

    task automatic test_reset_mid;
        int k0;
        ack_delay.delete();
        load_words(32'd7, 32'h00FFFFFF, 32'h00FFFFFF);
        start_xfer(32'd7, k0);
        for (int k = 0; k < BUDGET && rise_q.size() < 30; k++) @(posedge clk);
        total++; if (rise_q.size() < 30) begin bad++; $display("FAIL rstmid_reach got=%0d want=30", rise_q.size()); end
        repeat (5) @(posedge clk);
        @(negedge clk); reset = 1'b1; led_tx = 1'b0;
        #1;
        total++; if ({led_data, wbm_cycle, led_tx_done} !== 3'b000) begin bad++;
            $display("FAIL rstmid_outs got=%b want=000", {led_data, wbm_cycle, led_tx_done}); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rise_q.delete(); done_q.delete();
        repeat (TBIT * 30 + TRESET + 50) @(posedge clk);
        #1;
        total++; if (done_q.size() != 0 || rise_q.size() != 0) begin bad++;
            $display("FAIL rstmid_quiet got=%0d_done_%0d_pulses want=0_0", done_q.size(), rise_q.size()); end
        run_checked("after_rst", $urandom(), $urandom(), $urandom(), 1);
    endtask

    task automatic test_back_to_back;
        int  k0, done1, n_len, n_per;
        bit  ok;
        logic [31:0] a0, a1, b0, b1;
        a0 = $urandom(); a1 = $urandom(); b0 = $urandom(); b1 = $urandom();
        ack_delay.delete();
        load_words(32'd1, a0, a1);
        start_xfer(32'd1, k0);
        wait_done(BUDGET, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL b2b1_timeout got=no_done want=done"); end
        wave_errors(a0, a1, -1, n_len, n_per);
        total++; if (n_len + n_per !== 0 || done_q.size() != 1 || rd_addr.size() != N) begin bad++;
            $display("FAIL b2b1_wave got=%0d_errs_%0d_done_%0d_reads want=0_1_%0d", n_len + n_per,
                     done_q.size(), rd_addr.size(), N); end
        done1 = done_q.size() ? done_q[0] : 0;
        load_words(32'd2, b0, b1);
        start_xfer(32'd2, k0);
        wait_done(BUDGET, ok);
        repeat (10) @(posedge clk); #1;
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL b2b2_timeout got=no_done want=done"); end
        total++; if (rise_q.size() == 0 || rise_q[0] != done1 + 6) begin bad++;
            $display("FAIL b2b2_restart got=%0d want=%0d", rise_q.size() ? rise_q[0] - done1 : -1, 6); end
        wave_errors(b0, b1, -1, n_len, n_per);
        total++; if (n_len + n_per !== 0 || done_q.size() != 1 || rd_addr.size() != N) begin bad++;
            $display("FAIL b2b2_wave got=%0d_errs_%0d_done_%0d_reads want=0_1_%0d", n_len + n_per,
                     done_q.size(), rd_addr.size(), N); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_upper_byte;
        test_addressing;
        test_random;
        test_underrun;
        test_reset_mid;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
